// File: rtl/acc_pkg.sv
// acc_pkg: op encoding and next-value/overflow function for the accumulator bank (ACC_SAT_EN selects saturation)
package acc_pkg;
  localparam int MAX_W = 64;
  typedef logic [2:0] op_t;
  localparam op_t OP_NONE = 3'd0;
  localparam op_t OP_CLR  = 3'd1;
  localparam op_t OP_INC  = 3'd2;
  localparam op_t OP_DEC  = 3'd3;
  localparam op_t OP_LD   = 3'd4;
  localparam op_t OP_ALU  = 3'd5;
  localparam op_t OP_ADD  = 3'd6;
`ifdef ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  // Works on MAX_W-wide containers; w is the live width (w < MAX_W), returns {ovf, next_value}
  function automatic logic [MAX_W:0] acc_next(input logic [MAX_W-1:0] value, input op_t op,
                                               input logic [MAX_W-1:0] operand, input int w);
    logic [MAX_W-1:0] ones;
    logic [MAX_W:0] sum;
    logic [MAX_W-1:0] nxt;
    logic ovf;
    ones = {MAX_W{1'b1}} >> (MAX_W - w);
    sum = {1'b0, value} + {1'b0, operand};
    ovf = 1'b0;
    nxt = value;
    case (op)
      OP_CLR: nxt = '0;
      OP_INC: begin
        ovf = value == ones;
        nxt = ovf ? (SAT ? ones : '0) : value + MAX_W'(1);
      end
      OP_DEC: begin
        ovf = value == '0;
        nxt = ovf ? (SAT ? '0 : ones) : value - MAX_W'(1);
      end
      OP_LD, OP_ALU: nxt = operand;
      OP_ADD: begin
        ovf = (sum >> w) != '0;
        nxt = (ovf && SAT) ? ones : sum[MAX_W-1:0];
      end
      default: ;
    endcase
    return {ovf, nxt & ones};
  endfunction
endpackage

// File: rtl/acc_entry.sv
// acc_entry: one accumulator register with its sticky overflow flag
module acc_entry
  import acc_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  op_t              op,
  input  logic [ACC_W-1:0] operand,
  input  logic             ovf_clr,
  output logic [ACC_W-1:0] value,
  output logic             ovf
);
  logic [MAX_W:0]   res;
  logic [ACC_W-1:0] value_d, value_q;
  logic             ovf_d, ovf_q;
  logic             unused_hi;
  always_comb begin
    res = acc_next(MAX_W'(value_q), op, MAX_W'(operand), ACC_W);
    value_d = en ? res[ACC_W-1:0] : value_q;
    ovf_d = (en & res[MAX_W]) | (ovf_q & ~ovf_clr);
  end
  assign unused_hi = ^res[MAX_W-1:ACC_W];
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q <= ovf_d;
    end
  end
  assign value = value_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/acc_register_bank.sv
// acc_register_bank: NUM_ACC accumulators, one prioritised update per cycle; ACC_SAT_EN enables saturation
module acc_register_bank
  import acc_pkg::*;
#(
  parameter  int ACC_W   = 24,
  parameter  int NUM_ACC = 4,
  localparam int SEL_W   = $clog2(NUM_ACC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   sel,
  input  logic               clr,
  input  logic               incre,
  input  logic               decre,
  input  logic               write_en,
  input  logic               alu_to_ac,
  input  logic               acc_add,
  input  logic [ACC_W-1:0]   data_in,
  input  logic [ACC_W-1:0]   alu_out,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [ACC_W-1:0]   data_out,
  output logic               acc_zero,
  output logic [NUM_ACC-1:0] ovf_flags,
  input  logic [NUM_ACC-1:0] ovf_clr
);
  op_t              op;
  logic [ACC_W-1:0] operand;
  logic [ACC_W-1:0] vals [2**SEL_W];
  always_comb begin
    op = clr ? OP_CLR : incre ? OP_INC : decre ? OP_DEC : write_en ? OP_LD :
         alu_to_ac ? OP_ALU : acc_add ? OP_ADD : OP_NONE;
    operand = (op == OP_ALU) ? alu_out : data_in;
  end
  // Unused decode slots read as zero, so out-of-range selects drop updates and read 0
  for (genvar g = 0; g < 2**SEL_W; g++) begin : g_slot
    if (g < NUM_ACC) begin : g_entry
      acc_entry #(.ACC_W(ACC_W)) u_entry (
        .clk(clk), .rst(rst), .en(sel == SEL_W'(g)), .op(op), .operand(operand),
        .ovf_clr(ovf_clr[g]), .value(vals[g]), .ovf(ovf_flags[g])
      );
    end else begin : g_pad
      assign vals[g] = '0;
    end
  end
  assign data_out = vals[rd_sel];
  assign acc_zero = data_out == '0;
endmodule
